pump_rotation_ctrl: RTL and testbench

- Parametrised successor of the two-pump level controller.
- Drives N_PUMPS pumps from a bank of level sensors: the number of asserted sensors sets the number of pumps required.
- Rotates the lead pump after every full stop to equalise wear, skips faulted pumps, and enforces a minimum run (hold) time.
- Sits between the tank sensor inputs and the pump contactor outputs; all outputs are registered.

---
 rtl/pump_rotation_ctrl_if.sv | 25 ++
 rtl/pump_rotation_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pump_rotation_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pump_rotation_ctrl_if.sv
// Sensor/contactor bundle for pump_rotation_ctrl.
// master: tank side (drives level/fault, observes pump commands).
// slave:  controller side.
interface pump_rotation_ctrl_if #(
  parameter int unsigned N_PUMPS = 4
);
  localparam int unsigned IDX_W = $clog2(N_PUMPS);

  logic [N_PUMPS-1:0] level;
  logic [N_PUMPS-1:0] fault;
  logic [N_PUMPS-1:0] pump_on;
  logic [IDX_W-1:0]   lead_idx;
  logic               alarm;
  logic               level_err;

  modport master (
    output level, fault,
    input  pump_on, lead_idx, alarm, level_err
  );

  modport slave (
    input  level, fault,
    output pump_on, lead_idx, alarm, level_err
  );
endinterface

// File: rtl/pump_rotation_ctrl.sv
// Multi-pump level controller with lead rotation, fault skipping and minimum run time.
// The number of asserted level sensors sets the number of pumps required; the lead pump
// advances after every full stop so wear is spread across the bank.
// Optional feature: define STAGGER_START_EN to stage pump starts one at a time,
// at least STAGGER_CYCLES apart (the first start from idle is immediate).
module pump_rotation_ctrl #(
  parameter int unsigned N_PUMPS        = 4,
  parameter int unsigned HOLD_CYCLES    = 8,
  parameter int unsigned STAGGER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pump_rotation_ctrl_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(N_PUMPS);
  localparam int unsigned CW    = IDX_W + 1;
  localparam int unsigned HW    = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [HW-1:0]      r_hold;
  logic [IDX_W-1:0]   r_lead;
  logic [N_PUMPS-1:0] r_pump_on;
  logic               r_alarm;
  logic               r_level_err;

  state_e             w_state_d;
  logic [CW-1:0]      w_cnt_d;
  logic [IDX_W-1:0]   w_lead_d;
  logic [CW-1:0]      w_d;
  logic [CW-1:0]      w_a;
  logic [CW-1:0]      w_t;
  logic               w_inc;
  logic               w_therm;
  logic [N_PUMPS-1:0] w_lvl_inc;
  logic [N_PUMPS-1:0] w_sel;

`ifdef STAGGER_START_EN
  localparam int unsigned SW = $clog2(STAGGER_CYCLES + 1);
  logic [SW-1:0] r_stag;
`endif

  // Demand, availability and level-pattern sanity.
  always_comb begin
    w_d = '0;
    w_a = '0;
    for (int k = 0; k < N_PUMPS; k++) begin
      w_d = w_d + CW'(bus.level[k]);
      w_a = w_a + CW'(!bus.fault[k]);
    end
    w_t       = (w_d < w_a) ? w_d : w_a;
    // A thermometer code plus one has no bits in common with itself.
    w_lvl_inc = bus.level + {{(N_PUMPS-1){1'b0}}, 1'b1};
    w_therm   = ((bus.level & w_lvl_inc) == '0);
  end

  // Running-count update: fault clamp beats hold, then move toward target.
  always_comb begin
    w_cnt_d = r_cnt;
    w_inc   = 1'b0;
    if (w_a < r_cnt) begin
      w_cnt_d = w_a;
    end else if (w_t > r_cnt) begin
`ifdef STAGGER_START_EN
      if (r_cnt == '0) begin
        w_cnt_d = CW'(1);
        w_inc   = 1'b1;
      end else if (r_stag >= SW'(STAGGER_CYCLES)) begin
        w_cnt_d = r_cnt + CW'(1);
        w_inc   = 1'b1;
      end
`else
      w_cnt_d = w_t;
      w_inc   = 1'b1;
`endif
    end else if ((w_t < r_cnt) && (r_hold >= HW'(HOLD_CYCLES))) begin
      w_cnt_d = w_t;
    end
  end

  // FSM next state and lead rotation on every stop.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx       = 0;
    found     = 1'b0;
    w_state_d = r_state;
    w_lead_d  = r_lead;
    unique case (r_state)
      StIdle: if (w_cnt_d != '0) w_state_d = StRun;
      StRun:  if (w_cnt_d == '0) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if ((r_state == StRun) && (w_state_d == StIdle)) begin
      // k = N_PUMPS lands back on the lead, so a lone healthy lead keeps the role.
      for (int k = 1; k <= N_PUMPS; k++) begin
        idx = int'(r_lead) + k;
        if (idx >= N_PUMPS) idx = idx - N_PUMPS;
        if (!found && !bus.fault[idx]) begin
          w_lead_d = IDX_W'(idx);
          found    = 1'b1;
        end
      end
    end
  end

  // Pick the first w_cnt_d healthy pumps walking from the lead.
  always_comb begin
    int unsigned idx;
    logic [CW-1:0] n;
    idx   = 0;
    n     = '0;
    w_sel = '0;
    for (int k = 0; k < N_PUMPS; k++) begin
      idx = int'(r_lead) + k;
      if (idx >= N_PUMPS) idx = idx - N_PUMPS;
      if (!bus.fault[idx] && (n < w_cnt_d)) begin
        w_sel[idx] = 1'b1;
        n          = n + CW'(1);
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_lead      <= '0;
      r_pump_on   <= '0;
      r_alarm     <= 1'b0;
      r_level_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_lead      <= w_lead_d;
      r_pump_on   <= w_sel;
      r_alarm     <= (w_d > w_a);
      r_level_err <= !w_therm;
      if (w_inc)                          r_hold <= '0;
      else if (r_hold < HW'(HOLD_CYCLES)) r_hold <= r_hold + HW'(1);
    end
  end

`ifdef STAGGER_START_EN
  // Spacing between successive starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           r_stag <= '0;
    else if (w_inc)                         r_stag <= '0;
    else if (r_stag < SW'(STAGGER_CYCLES))  r_stag <= r_stag + SW'(1);
  end
`endif

  assign bus.pump_on   = r_pump_on;
  assign bus.lead_idx  = r_lead;
  assign bus.alarm     = r_alarm;
  assign bus.level_err = r_level_err;

endmodule

// File: tb/tb_pump_rotation_ctrl.sv
// Directed bench for pump_rotation_ctrl (N_PUMPS=4, HOLD_CYCLES=8, default build).
module tb_pump_rotation_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pump_rotation_ctrl_if #(.N_PUMPS(4)) bus ();

  pump_rotation_ctrl #(
    .N_PUMPS        (4),
    .HOLD_CYCLES    (8),
    .STAGGER_CYCLES (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    bus.level = 4'b0000;
    bus.fault = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    if (bus.pump_on !== 4'b0000) begin
      failures++; $display("FAIL reset_pump_on got %b want 0000", bus.pump_on);
    end
    checks++;
    if (bus.lead_idx !== 2'd0) begin
      failures++; $display("FAIL reset_lead got %0d want 0", bus.lead_idx);
    end
    checks++;
    if (bus.alarm !== 1'b0 || bus.level_err !== 1'b0) begin
      failures++; $display("FAIL reset_flags got %b%b want 00", bus.alarm, bus.level_err);
    end
    checks++;
  endtask

  // Single pump start, held for the minimum run time, then rotation of the lead.
  task automatic test_start_hold_rotate();
    bus.level = 4'b0001;
    tick();
    if (bus.pump_on !== 4'b0001) begin
      failures++; $display("FAIL start_pump_on got %b want 0001", bus.pump_on);
    end
    checks++;
    bus.level = 4'b0000;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.pump_on !== 4'b0001) begin
        failures++; $display("FAIL hold_pump_on cyc %0d got %b want 0001", i, bus.pump_on);
      end
      checks++;
    end
    tick();
    if (bus.pump_on !== 4'b0000) begin
      failures++; $display("FAIL stop_pump_on got %b want 0000", bus.pump_on);
    end
    checks++;
    if (bus.lead_idx !== 2'd1) begin
      failures++; $display("FAIL rotate_lead got %0d want 1", bus.lead_idx);
    end
    checks++;
    bus.level = 4'b0001;
    tick();
    if (bus.pump_on !== 4'b0010) begin
      failures++; $display("FAIL restart_pump_on got %b want 0010", bus.pump_on);
    end
    checks++;
  endtask

  // Entered with lead=1 and one pump running.
  task automatic test_reset_mid_run();
    bus.level = 4'b0111;
    tick();
    if (bus.pump_on !== 4'b1110) begin
      failures++; $display("FAIL grow_from_lead1 got %b want 1110", bus.pump_on);
    end
    checks++;
    #3;
    reset_n = 1'b0;
    #1;
    if (bus.pump_on !== 4'b0000 || bus.lead_idx !== 2'd0) begin
      failures++;
      $display("FAIL async_reset got pump_on=%b lead=%0d want 0000/0", bus.pump_on,
               bus.lead_idx);
    end
    checks++;
    #1;
    bus.level = 4'b0001;
    reset_n   = 1'b1;
    tick();
    if (bus.pump_on !== 4'b0001) begin
      failures++; $display("FAIL post_reset_start got %b want 0001", bus.pump_on);
    end
    checks++;
  endtask

  // Multi-pump start, then a partial decrease after the hold time.
  task automatic test_multi_and_decrease();
    do_reset();
    bus.level = 4'b0111;
    tick();
    if (bus.pump_on !== 4'b0111) begin
      failures++; $display("FAIL multi_start got %b want 0111", bus.pump_on);
    end
    checks++;
    bus.level = 4'b0001;
    repeat (8) tick();
    if (bus.pump_on !== 4'b0111) begin
      failures++; $display("FAIL decrease_held got %b want 0111", bus.pump_on);
    end
    checks++;
    tick();
    if (bus.pump_on !== 4'b0001 || bus.lead_idx !== 2'd0) begin
      failures++;
      $display("FAIL decrease_done got pump_on=%b lead=%0d want 0001/0", bus.pump_on,
               bus.lead_idx);
    end
    checks++;
  endtask

  task automatic test_fault_swap();
    do_reset();
    bus.level = 4'b0011;
    tick();
    if (bus.pump_on !== 4'b0011) begin
      failures++; $display("FAIL swap_pre got %b want 0011", bus.pump_on);
    end
    checks++;
    bus.fault = 4'b0010;
    tick();
    if (bus.pump_on !== 4'b0101 || bus.alarm !== 1'b0) begin
      failures++;
      $display("FAIL fault_swap got pump_on=%b alarm=%b want 0101/0", bus.pump_on, bus.alarm);
    end
    checks++;
  endtask

  task automatic test_overload();
    do_reset();
    bus.level = 4'b1111;
    bus.fault = 4'b0001;
    tick();
    if (bus.pump_on !== 4'b1110 || bus.alarm !== 1'b1) begin
      failures++;
      $display("FAIL overload got pump_on=%b alarm=%b want 1110/1", bus.pump_on, bus.alarm);
    end
    checks++;
    bus.fault = 4'b0000;
    tick();
    if (bus.pump_on !== 4'b1111 || bus.alarm !== 1'b0) begin
      failures++;
      $display("FAIL overload_clear got pump_on=%b alarm=%b want 1111/0", bus.pump_on,
               bus.alarm);
    end
    checks++;
    // Losing two pumps clamps immediately even inside the hold window.
    bus.fault = 4'b0011;
    tick();
    if (bus.pump_on !== 4'b1100 || bus.alarm !== 1'b1) begin
      failures++;
      $display("FAIL fault_clamp got pump_on=%b alarm=%b want 1100/1", bus.pump_on, bus.alarm);
    end
    checks++;
    bus.fault = 4'b1111;
    tick();
    if (bus.pump_on !== 4'b0000 || bus.lead_idx !== 2'd0) begin
      failures++;
      $display("FAIL all_faulted got pump_on=%b lead=%0d want 0000/0", bus.pump_on,
               bus.lead_idx);
    end
    checks++;
  endtask

  // Stop while the next index is faulted: rotation skips it.
  task automatic test_rotate_skip();
    do_reset();
    bus.level = 4'b0001;
    tick();
    bus.level = 4'b0000;
    bus.fault = 4'b0010;
    repeat (9) tick();
    if (bus.pump_on !== 4'b0000 || bus.lead_idx !== 2'd2) begin
      failures++;
      $display("FAIL rotate_skip got pump_on=%b lead=%0d want 0000/2", bus.pump_on,
               bus.lead_idx);
    end
    checks++;
  endtask

  task automatic test_sensor_err();
    do_reset();
    bus.level = 4'b0101;
    tick();
    if (bus.level_err !== 1'b1 || bus.pump_on !== 4'b0011) begin
      failures++;
      $display("FAIL sensor_err got err=%b pump_on=%b want 1/0011", bus.level_err, bus.pump_on);
    end
    checks++;
    bus.level = 4'b0011;
    tick();
    if (bus.level_err !== 1'b0 || bus.pump_on !== 4'b0011) begin
      failures++;
      $display("FAIL sensor_ok got err=%b pump_on=%b want 0/0011", bus.level_err, bus.pump_on);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_start_hold_rotate();
    test_reset_mid_run();
    test_multi_and_decrease();
    test_fault_swap();
    test_overload();
    test_rotate_skip();
    test_sensor_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
